// File: rtl/display_scan_controller.sv
// display_scan_controller
//
// Time-multiplexes one registered hex-to-7-segment converter across
// NUM_DIGITS common-anode digits. A writer updates a shadow bank of digit
// values through a valid/ready port. The whole shadow bank is copied to the
// active bank at each frame boundary. The display always shows the active
// bank, so a frame never mixes old and new values.
//
// Each digit slot has two phases. BLANK holds all anodes off for
// BLANK_CYCLES cycles. SHOW holds the digit's anode on for REFRESH_DIV
// cycles. The nibble for a digit is placed on dado when its BLANK phase
// starts. That gives the converter's one-cycle output register time to
// settle before the anode turns on.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset
//   wr_valid     writer presents a digit update
//   wr_ready     update accepted this cycle (low only in the commit cycle)
//   wr_digit     target digit index, 0 = rightmost
//   wr_value     hex nibble for that digit
//   wr_blank     1 = digit stays dark regardless of value
//   dado         nibble driven to the converter input (registered)
//   an           anode enables, active low (registered)
//   frame_start  one-cycle pulse in the first cycle of each committed frame

module display_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IDXW-1:0]       wr_digit,
  input  logic [3:0]            wr_value,
  input  logic                  wr_blank,
  output logic [3:0]            dado,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_start
);

  localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0]   SHOW_LAST  = CW'(REFRESH_DIV - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IDXW-1:0]       idx, idx_n, idx_wrap;
  logic [NUM_DIGITS-1:0] an_n, show_mask;
  logic                  enter_blank;
  logic                  commit;

  logic [3:0]            sh_val  [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] sh_blank;
  logic [3:0]            act_val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] act_blank;

  assign idx_wrap = (idx == LAST_IDX) ? '0 : idx + 1'b1;

  // A blanked digit keeps every anode off for its whole SHOW phase.
  always_comb begin
    show_mask = '1;
    if (!act_blank[idx]) show_mask[idx] = 1'b0;
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 1'b1;
    idx_n       = idx;
    an_n        = an;
    enter_blank = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = SHOW;
          cnt_n   = '0;
          an_n    = show_mask;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_n     = BLANK;
          cnt_n       = '0;
          idx_n       = idx_wrap;
          an_n        = '1;
          enter_blank = 1'b1;
        end
      end
    endcase
  end

  // Leaving the last digit's SHOW phase ends the frame. The shadow bank is
  // copied in that cycle, so writes are refused for that one cycle.
  assign commit   = enter_blank && (idx == LAST_IDX);
  assign wr_ready = ~commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= '0;
      an          <= '1;
      dado        <= '0;
      frame_start <= 1'b0;
      sh_blank    <= '1;
      act_blank   <= '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        sh_val[i]  <= '0;
        act_val[i] <= '0;
      end
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      an          <= an_n;
      frame_start <= commit;

      // On commit the active bank is still stale. Digit 0's nibble is
      // therefore taken straight from the shadow bank.
      if (commit) begin
        for (int i = 0; i < NUM_DIGITS; i++) act_val[i] <= sh_val[i];
        act_blank <= sh_blank;
        dado      <= sh_val[0];
      end else if (enter_blank) begin
        dado <= act_val[idx_wrap];
      end

      // An out-of-range index matches no digit, so that update is dropped.
      if (wr_valid && wr_ready) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (wr_digit == i[IDXW-1:0]) begin
            sh_val[i]   <= wr_value;
            sh_blank[i] <= wr_blank;
          end
        end
      end
    end
  end

endmodule
